adder_sequencer: RTL and testbench
==================================

Name: adder_sequencer

Overview:
- Control-side initiator for the adder/accumulator datapath. Accepts simple commands over a valid/ready handshake and drives the datapath's operand bus byte and packed control byte (select, nLa, nLb, Ea, Eu, sub) with correct cycle timing.
- Samples the datapath's accumulator output and CF/ZF flags, and returns a response over a second valid/ready handshake.
- Sits between a host command source and the datapath's ui_in/uio_in pins.

Parameters:
- SETTLE_CYCLES, 1: cycles the operand is held on bus_data before the load strobe; covers the datapath's registered input buffer. Legal range 1..15.
- DATA_W, 8: datapath width.

Ports:
- clk  in  1  clock
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 OUT; 5-7 illegal
- cmd_data  in  DATA_W  operand
- rsp_valid  out  1  response available
- rsp_ready  in  1  host takes the response
- rsp_data  out  DATA_W  accumulator value captured for the command
- rsp_cf  out  1  latched carry flag
- rsp_zf  out  1  latched zero flag
- rsp_err  out  1  illegal opcode
- bus_data  out  DATA_W  to datapath ui_in
- ctl_out  out  8  to datapath uio_in: [7]=bus_regA_sel, [6]=nLa, [5]=nLb, [4]=Ea, [3]=Eu, [2]=sub, [1:0]=0
- acc_in  in  DATA_W  from datapath uo_out (regA when bus_regA_sel=0)
- flag_in  in  2  from datapath uio_out: [1]=CF, [0]=ZF

Behaviour:
- Idle control value is ctl_out=8'h60 (nLa=1, nLb=1, all others 0). bus_data=0 outside the DRIVE/LOADA/LOADB states.
- Reset values: state IDLE; cmd_ready=1; rsp_valid=0; rsp_data=0; rsp_cf=0; rsp_zf=0; rsp_err=0; bus_data=0; ctl_out=8'h60; settle counter=0.
- All outputs are registered or decoded from registered state. No combinational path from cmd_*/rsp_ready to ctl_out or bus_data.
- States: IDLE, DRIVE, LOADA, LOADB, EXEC, WB, CAP, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid & cmd_ready, latch op and data.
  - LDA/ADD/SUB go to DRIVE with the counter set to SETTLE_CYCLES.
  - NOP/OUT go to CAP.
  - Illegal ops go to RESP with rsp_err=1 and rsp_data=0.
- DRIVE: bus_data=operand. The counter decrements each cycle. At 1, LDA goes to LOADA; ADD/SUB go to LOADB.
- LOADA: bus_data=operand, nLa=0 for exactly 1 cycle, then CAP.
- LOADB: bus_data=operand, nLb=0 for exactly 1 cycle, then EXEC.
- EXEC: Eu=1, sub=(op==SUB), 1 cycle, then WB.
- WB:
  - Eu=1, sub held, nLa=0 for 1 cycle.
  - Flag register <= flag_in at the end of WB.
  - Then CAP.
- CAP:
  - Ea=1 only for OUT. Otherwise idle controls.
  - rsp_data <= acc_in. Then RESP.
- RESP:
  - rsp_valid=1, cmd_ready=0.
  - rsp_data, rsp_cf, rsp_zf and rsp_err stay stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE and clear rsp_err. cmd_ready is 1 on the next cycle.
  - A new command is never accepted in the same cycle as the response handshake.
- Flags update only on ADD/SUB. LDA, OUT and NOP leave rsp_cf/rsp_zf unchanged.
- Latency from the accept edge to rsp_valid high:
  - LDA: SETTLE_CYCLES+3
  - ADD/SUB: SETTLE_CYCLES+5
  - NOP/OUT: 2
  - Illegal: 1
- nLa and nLb are never both low. Eu and the nLb strobe never coincide.
- rst asserted in any state (including mid-WB) forces all reset values immediately. The in-flight command is dropped and no response is produced.
- cmd_data/cmd_op changing while cmd_valid=0 or cmd_ready=0 has no effect.

Decomposition:
- Package adder_seq_pkg holds:
  - opcode constants OP_NOP..OP_OUT
  - the state enum
  - control bit-index constants CTL_SEL/CTL_NLA/CTL_NLB/CTL_EA/CTL_EU/CTL_SUB
  - CTL_IDLE=8'h60
- One sub-module, adder_seq_settle_timer: a loadable down-counter with a done pulse, used by DRIVE.

Test Plan:
- Reset, then LDA 8'h12 with SETTLE=1 (bench datapath model attached) -> nLa low exactly 1 cycle, bus_data=8'h12 for 2 cycles before and during the strobe, rsp_data=8'h12 at cycle 4, rsp_cf=0, rsp_zf=0.
- LDA 8'h12, then ADD 8'h30 -> nLb strobe, then 1 EXEC cycle, then WB with Eu=1/nLa=0 -> rsp_data=8'h42, cf=0, zf=0, rsp_valid at cycle 6.
- Acc=8'h42, then SUB 8'h42 -> rsp_data=8'h00, zf=1, cf=1. Then LDA 8'h05 -> rsp_data=8'h05, flags still cf=1, zf=1.
- Acc=8'h20, then ADD 8'hF0 -> rsp_data=8'h10, cf=1, zf=0. Then OUT -> Ea=1 for 1 cycle, rsp_data=8'h10, latency 2.
- Hold rsp_ready=0 for 5 cycles -> rsp fields stable, cmd_ready=0, further cmd_valid ignored. Opcode 3'd6 -> rsp_err=1, rsp_data=0, latency 1.
- Assert rst during WB of an ADD -> ctl_out=8'h60 and bus_data=0 immediately, rsp_valid=0, flags=0. After release, a new LDA 8'hAA completes normally.

Source files
------------

// File: rtl/adder_sequencer_pkg.sv
// rtl/adder_sequencer_pkg.sv - shared opcodes, FSM states and control-byte layout for adder_sequencer
//
// Holds the host opcode encoding, the sequencer state enum, bit positions
// inside the datapath control byte and the idle control value.
package adder_seq_pkg;

  localparam int OP_W     = 3;
  localparam int SETTLE_W = 4;

  localparam logic [OP_W-1:0] OP_NOP = 3'd0;
  localparam logic [OP_W-1:0] OP_LDA = 3'd1;
  localparam logic [OP_W-1:0] OP_ADD = 3'd2;
  localparam logic [OP_W-1:0] OP_SUB = 3'd3;
  localparam logic [OP_W-1:0] OP_OUT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_LOADA,
    S_LOADB,
    S_EXEC,
    S_WB,
    S_CAP,
    S_RESP
  } state_e;

  // Bit positions inside the datapath control byte (uio_in).
  localparam int CTL_SEL = 7;
  localparam int CTL_NLA = 6;
  localparam int CTL_NLB = 5;
  localparam int CTL_EA  = 4;
  localparam int CTL_EU  = 3;
  localparam int CTL_SUB = 2;

  // nLa=1, nLb=1, every enable low.
  localparam logic [7:0] CTL_IDLE = 8'h60;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return op <= OP_OUT;
  endfunction

  function automatic logic op_uses_operand(input logic [OP_W-1:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/adder_sequencer_if.sv
// rtl/adder_sequencer_if.sv - host command/response handshake bundle for adder_sequencer
//
// master : host side, offers commands and consumes responses
// slave  : sequencer side
//   cmd_valid/cmd_ready/cmd_op/cmd_data  command channel
//   rsp_valid/rsp_ready/rsp_data/rsp_cf/rsp_zf/rsp_err  response channel
interface adder_sequencer_if
  import adder_seq_pkg::*;
#(
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [DATA_W-1:0] cmd_data;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_cf;
  logic              rsp_zf;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_cf, rsp_zf, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_cf, rsp_zf, rsp_err
  );
endinterface

// File: rtl/adder_seq_settle_timer.sv
// rtl/adder_seq_settle_timer.sv - loadable down-counter that flags the last settle cycle
//
// clk, rst     : clock, asynchronous active-high reset
// load_i       : load load_val_i into the counter
// load_val_i   : number of cycles to count
// en_i         : count down this cycle
// done_o       : high during the final counted cycle (count==1 while enabled)
module adder_seq_settle_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = en_i && (count_q == CNT_W'(1));

endmodule

// File: rtl/adder_sequencer.sv
// rtl/adder_sequencer.sv - command sequencer driving the adder/accumulator datapath pins
//
// clk, rst     : clock, asynchronous active-high reset
// host         : command/response handshake (slave modport)
// bus_data_o   : operand byte to datapath ui_in
// ctl_out_o    : control byte to datapath uio_in {sel,nLa,nLb,Ea,Eu,sub,2'b00}
// acc_in_i     : accumulator (regA) from datapath uo_out
// flag_in_i    : {CF,ZF} from datapath uio_out
module adder_sequencer
  import adder_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int DATA_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  adder_sequencer_if.slave   host,
  output logic [DATA_W-1:0]  bus_data_o,
  output logic [7:0]         ctl_out_o,
  input  logic [DATA_W-1:0]  acc_in_i,
  input  logic [1:0]         flag_in_i
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              cf_q, cf_d;
  logic              zf_q, zf_d;
  logic              err_q, err_d;
  logic              accept;
  logic              settle_done;

  assign accept = host.cmd_valid && (state_q == S_IDLE);

  // Loaded on every accept; only consulted while in DRIVE.
  adder_seq_settle_timer #(
    .CNT_W (SETTLE_W)
  ) u_settle (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .load_val_i (SETTLE_W'(SETTLE_CYCLES)),
    .en_i       (state_q == S_DRIVE),
    .done_o     (settle_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (host.cmd_valid) begin
          if (op_uses_operand(host.cmd_op)) begin
            state_d = S_DRIVE;
          end else if (op_is_legal(host.cmd_op)) begin
            state_d = S_CAP;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_DRIVE: begin
        if (settle_done) begin
          state_d = (op_q == OP_LDA) ? S_LOADA : S_LOADB;
        end
      end
      S_LOADA: state_d = S_CAP;
      S_LOADB: state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_CAP;
      S_CAP:   state_d = S_RESP;
      S_RESP: begin
        if (host.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand bus and control byte are pure decodes of registered state.
  always_comb begin
    ctl_out_o  = CTL_IDLE;
    bus_data_o = '0;
    case (state_q)
      S_DRIVE: bus_data_o = data_q;
      S_LOADA: begin
        bus_data_o         = data_q;
        ctl_out_o[CTL_NLA] = 1'b0;
      end
      S_LOADB: begin
        bus_data_o         = data_q;
        ctl_out_o[CTL_NLB] = 1'b0;
      end
      S_EXEC: begin
        ctl_out_o[CTL_EU]  = 1'b1;
        ctl_out_o[CTL_SUB] = (op_q == OP_SUB);
      end
      S_WB: begin
        // ALU result is written back into regA while Eu still selects it.
        ctl_out_o[CTL_EU]  = 1'b1;
        ctl_out_o[CTL_SUB] = (op_q == OP_SUB);
        ctl_out_o[CTL_NLA] = 1'b0;
      end
      S_CAP:   ctl_out_o[CTL_EA] = (op_q == OP_OUT);
      default: ;
    endcase
  end

  assign host.cmd_ready = (state_q == S_IDLE);
  assign host.rsp_valid = (state_q == S_RESP);
  assign host.rsp_data  = rsp_data_q;
  assign host.rsp_cf    = cf_q;
  assign host.rsp_zf    = zf_q;
  assign host.rsp_err   = err_q;

  always_comb begin
    op_d       = op_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    cf_d       = cf_q;
    zf_d       = zf_q;
    err_d      = err_q;
    if (accept) begin
      op_d   = host.cmd_op;
      data_d = host.cmd_data;
      if (!op_is_legal(host.cmd_op)) begin
        err_d      = 1'b1;
        rsp_data_d = '0;
      end
    end
    // Only ADD/SUB pass through WB, so flags stay put for every other op.
    if (state_q == S_WB) begin
      cf_d = flag_in_i[1];
      zf_d = flag_in_i[0];
    end
    if (state_q == S_CAP) begin
      rsp_data_d = acc_in_i;
    end
    if ((state_q == S_RESP) && host.rsp_ready) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= OP_NOP;
      data_q     <= '0;
      rsp_data_q <= '0;
      cf_q       <= 1'b0;
      zf_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      op_q       <= op_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      cf_q       <= cf_d;
      zf_q       <= zf_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_adder_sequencer.sv
// tb/tb_adder_sequencer.sv - self-checking bench for adder_sequencer with a datapath model attached
module tb_adder_sequencer;
  import adder_seq_pkg::*;

  localparam int S  = 1;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_sequencer_if #(.DATA_W(DW)) host_if ();

  logic [7:0] bus_data, ctl_out, acc_in;
  logic [1:0] flag_in;

  adder_sequencer #(.SETTLE_CYCLES(S), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .host       (host_if),
    .bus_data_o (bus_data),
    .ctl_out_o  (ctl_out),
    .acc_in_i   (acc_in),
    .flag_in_i  (flag_in)
  );

  // Datapath stand-in: registered input buffer, regA/regB, add/sub ALU.
  logic [7:0] dp_buf, dp_a, dp_b;
  logic [8:0] dp_alu;
  always_comb dp_alu = ctl_out[CTL_SUB] ? ({1'b0, dp_a} + {1'b0, ~dp_b} + 9'd1)
                                        : ({1'b0, dp_a} + {1'b0, dp_b});
  assign acc_in  = dp_a;
  assign flag_in = {dp_alu[8], (dp_alu[7:0] == 8'h00)};
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_buf <= 8'h00; dp_a <= 8'h00; dp_b <= 8'h00;
    end else begin
      dp_buf <= bus_data;
      if (!ctl_out[CTL_NLA]) dp_a <= ctl_out[CTL_EU] ? dp_alu[7:0] : dp_buf;
      if (!ctl_out[CTL_NLB]) dp_b <= dp_buf;
    end
  end

  int tests = 0;
  int fails = 0;

  // Reference model of what the host should observe.
  logic [7:0] acc_m = 8'h00;
  logic       cf_m  = 1'b0;
  logic       zf_m  = 1'b0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got hang want finish");
    $fatal(1);
  end

  task automatic do_cmd(input logic [2:0] op, input logic [7:0] d, input int hold, input string tag);
    logic [7:0] exp_data, exp_bus, sd;
    logic exp_err, uses, arith, scf, szf, serr;
    int exp_lat, k, nla, nlb, eu, sub_n, ea, bad_inv, bad_bus, strobe_at, unstable;
    uses  = (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
    arith = (op == OP_ADD) || (op == OP_SUB);
    exp_err = 1'b0;
    exp_lat = 2;
    case (op)
      OP_LDA: begin acc_m = d; exp_lat = S + 3; end
      OP_ADD: begin
        cf_m = (int'(acc_m) + int'(d)) > 255;
        acc_m = 8'(int'(acc_m) + int'(d));
        zf_m = (acc_m == 8'h00);
        exp_lat = S + 5;
      end
      OP_SUB: begin
        cf_m = (acc_m >= d);
        acc_m = 8'(int'(acc_m) - int'(d));
        zf_m = (acc_m == 8'h00);
        exp_lat = S + 5;
      end
      OP_NOP, OP_OUT: exp_lat = 2;
      default: begin exp_lat = 1; exp_err = 1'b1; end
    endcase
    exp_data = exp_err ? 8'h00 : acc_m;

    tests++;
    if (host_if.cmd_ready !== 1'b1) begin
      fails++; $display("FAIL %s cmd_ready_before: got %b want 1", tag, host_if.cmd_ready);
    end

    host_if.cmd_valid = 1'b1; host_if.cmd_op = op; host_if.cmd_data = d;
    k = 0; nla = 0; nlb = 0; eu = 0; sub_n = 0; ea = 0; bad_inv = 0; bad_bus = 0; strobe_at = 0;
    while (k < 40) begin
      @(posedge clk); #1; k++;
      if (k == 1) begin
        host_if.cmd_valid = 1'b0;
        host_if.cmd_op    = 3'($urandom);
        host_if.cmd_data  = 8'($urandom);
      end
      exp_bus = (uses && k <= S + 1) ? d : 8'h00;
      if (bus_data !== exp_bus) bad_bus++;
      if (!ctl_out[CTL_NLA]) begin nla++; if (strobe_at == 0) strobe_at = k; end
      if (!ctl_out[CTL_NLB]) begin nlb++; if (strobe_at == 0) strobe_at = k; end
      if (ctl_out[CTL_EU]) eu++;
      if (ctl_out[CTL_EU] && ctl_out[CTL_SUB]) sub_n++;
      if (ctl_out[CTL_EA]) ea++;
      if ((!ctl_out[CTL_NLA] && !ctl_out[CTL_NLB]) || (ctl_out[CTL_EU] && !ctl_out[CTL_NLB]) ||
          ctl_out[CTL_SEL] || (ctl_out[1:0] != 2'b00) || (ctl_out[CTL_SUB] && !ctl_out[CTL_EU]))
        bad_inv++;
      if (host_if.rsp_valid === 1'b1) break;
    end

    tests++;
    if (host_if.rsp_valid !== 1'b1 || k != exp_lat) begin
      fails++; $display("FAIL %s latency: got %0d (rsp_valid=%b) want %0d", tag, k, host_if.rsp_valid, exp_lat);
    end
    tests++;
    if (host_if.rsp_data !== exp_data) begin
      fails++; $display("FAIL %s rsp_data: got %h want %h", tag, host_if.rsp_data, exp_data);
    end
    tests++;
    if (host_if.rsp_cf !== cf_m || host_if.rsp_zf !== zf_m) begin
      fails++; $display("FAIL %s flags: got cf=%b zf=%b want cf=%b zf=%b", tag, host_if.rsp_cf, host_if.rsp_zf, cf_m, zf_m);
    end
    tests++;
    if (host_if.rsp_err !== exp_err) begin
      fails++; $display("FAIL %s rsp_err: got %b want %b", tag, host_if.rsp_err, exp_err);
    end
    tests++;
    if (bad_bus != 0) begin
      fails++; $display("FAIL %s bus_data_timing: got %0d wrong cycles want 0", tag, bad_bus);
    end
    tests++;
    if (bad_inv != 0) begin
      fails++; $display("FAIL %s ctl_invariants: got %0d bad cycles want 0", tag, bad_inv);
    end
    tests++;
    if (nla != (uses ? 1 : 0) || nlb != (arith ? 1 : 0) || strobe_at != (uses ? S + 1 : 0)) begin
      fails++; $display("FAIL %s load_strobes: got nla=%0d nlb=%0d first=%0d want nla=%0d nlb=%0d first=%0d",
                        tag, nla, nlb, strobe_at, uses ? 1 : 0, arith ? 1 : 0, uses ? S + 1 : 0);
    end
    tests++;
    if (eu != (arith ? 2 : 0) || sub_n != ((op == OP_SUB) ? 2 : 0) || ea != ((op == OP_OUT) ? 1 : 0)) begin
      fails++; $display("FAIL %s enables: got eu=%0d sub=%0d ea=%0d want eu=%0d sub=%0d ea=%0d", tag, eu, sub_n, ea,
                        arith ? 2 : 0, (op == OP_SUB) ? 2 : 0, (op == OP_OUT) ? 1 : 0);
    end

    // Back-pressure: response must hold and new commands must be ignored.
    sd = host_if.rsp_data; scf = host_if.rsp_cf; szf = host_if.rsp_zf; serr = host_if.rsp_err;
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      host_if.cmd_valid = 1'b1;
      host_if.cmd_op    = 3'($urandom);
      host_if.cmd_data  = 8'($urandom);
      @(posedge clk); #1;
      if (host_if.rsp_valid !== 1'b1 || host_if.cmd_ready !== 1'b0 || host_if.rsp_data !== sd ||
          host_if.rsp_cf !== scf || host_if.rsp_zf !== szf || host_if.rsp_err !== serr)
        unstable++;
    end
    if (hold > 0) begin
      tests++;
      if (unstable != 0) begin
        fails++; $display("FAIL %s rsp_hold: got %0d unstable cycles want 0", tag, unstable);
      end
    end

    host_if.rsp_ready = 1'b1;
    @(posedge clk); #1;
    host_if.rsp_ready = 1'b0;
    host_if.cmd_valid = 1'b0;
    tests++;
    if (host_if.rsp_valid !== 1'b0 || host_if.cmd_ready !== 1'b1 || host_if.rsp_err !== 1'b0) begin
      fails++; $display("FAIL %s handshake: got valid=%b ready=%b err=%b want 0 1 0", tag,
                        host_if.rsp_valid, host_if.cmd_ready, host_if.rsp_err);
    end
    @(posedge clk); #1;
    tests++;
    if (host_if.cmd_ready !== 1'b1) begin
      fails++; $display("FAIL %s no_accept_at_handshake: got cmd_ready=%b want 1", tag, host_if.cmd_ready);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (host_if.cmd_ready !== 1'b1 || host_if.rsp_valid !== 1'b0 || host_if.rsp_data !== 8'h00 ||
        host_if.rsp_cf !== 1'b0 || host_if.rsp_zf !== 1'b0 || host_if.rsp_err !== 1'b0 ||
        bus_data !== 8'h00 || ctl_out !== 8'h60) begin
      fails++; $display("FAIL reset_values: got ready=%b valid=%b data=%h cf=%b zf=%b err=%b bus=%h ctl=%h want 1 0 00 0 0 0 00 60",
                        host_if.cmd_ready, host_if.rsp_valid, host_if.rsp_data, host_if.rsp_cf,
                        host_if.rsp_zf, host_if.rsp_err, bus_data, ctl_out);
    end
    @(negedge clk);
    rst = 1'b0;
    acc_m = 8'h00; cf_m = 1'b0; zf_m = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (host_if.cmd_ready !== 1'b1 || ctl_out !== 8'h60 || bus_data !== 8'h00) begin
      fails++; $display("FAIL reset_release: got ready=%b ctl=%h bus=%h want 1 60 00", host_if.cmd_ready, ctl_out, bus_data);
    end
  endtask

  task automatic test_lda();
    do_cmd(OP_LDA, 8'h12, 0, "lda_12");
  endtask

  task automatic test_add();
    do_cmd(OP_ADD, 8'h30, 0, "add_30");
  endtask

  task automatic test_sub_flags();
    do_cmd(OP_SUB, 8'h42, 0, "sub_42");
    do_cmd(OP_LDA, 8'h05, 0, "lda_05_flags_kept");
  endtask

  task automatic test_out();
    do_cmd(OP_LDA, 8'h20, 0, "lda_20");
    do_cmd(OP_ADD, 8'hF0, 0, "add_f0");
    do_cmd(OP_OUT, 8'h00, 0, "out");
  endtask

  task automatic test_backpressure_illegal();
    do_cmd(OP_NOP, 8'h77, 5, "nop_hold5");
    do_cmd(3'd6, 8'h99, 0, "illegal_6");
    do_cmd(3'd7, 8'h3C, 2, "illegal_7_hold2");
    do_cmd(OP_OUT, 8'h00, 0, "out_after_illegal");
  endtask

  task automatic test_reset_mid_wb();
    int k, quiet;
    logic found;
    do_cmd(OP_LDA, 8'h80, 0, "lda_80");
    do_cmd(OP_ADD, 8'h80, 0, "add_80_flags_set");
    host_if.cmd_valid = 1'b1; host_if.cmd_op = OP_ADD; host_if.cmd_data = 8'h11;
    k = 0; found = 1'b0;
    while (k < 20 && !found) begin
      @(posedge clk); #1; k++;
      if (k == 1) host_if.cmd_valid = 1'b0;
      if (!ctl_out[CTL_NLA] && ctl_out[CTL_EU]) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL rst_wb_reach: got no WB cycle in %0d cycles want WB", k);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (ctl_out !== 8'h60 || bus_data !== 8'h00 || host_if.rsp_valid !== 1'b0 || host_if.rsp_cf !== 1'b0 ||
        host_if.rsp_zf !== 1'b0 || host_if.cmd_ready !== 1'b1) begin
      fails++; $display("FAIL rst_wb_immediate: got ctl=%h bus=%h valid=%b cf=%b zf=%b ready=%b want 60 00 0 0 0 1",
                        ctl_out, bus_data, host_if.rsp_valid, host_if.rsp_cf, host_if.rsp_zf, host_if.cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    acc_m = 8'h00; cf_m = 1'b0; zf_m = 1'b0;
    quiet = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (host_if.rsp_valid !== 1'b0 || host_if.cmd_ready !== 1'b1) quiet++;
    end
    tests++;
    if (quiet != 0) begin
      fails++; $display("FAIL rst_wb_dropped: got %0d cycles with response or busy want 0", quiet);
    end
    do_cmd(OP_LDA, 8'hAA, 0, "lda_aa_after_rst");
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [7:0] d;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      d  = 8'($urandom);
      do_cmd(op, d, $urandom_range(0, 3), $sformatf("rand%0d_op%0d", i, op));
    end
  endtask

  initial begin
    host_if.cmd_valid = 1'b0;
    host_if.cmd_op    = 3'd0;
    host_if.cmd_data  = 8'h00;
    host_if.rsp_ready = 1'b0;
    test_reset();
    test_lda();
    test_add();
    test_sub_flags();
    test_out();
    test_backpressure_illegal();
    test_reset_mid_wb();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
